div_float: RTL and testbench

- Sequential IEEE-754 floating-point divider: op1 / op2. Single or double precision, selected by parameter.
- Inverse companion to the team's floating-point multiplier. Same start/done/flag interface and same special-value constants, so the arithmetic unit can drive either block from one control path.
- Mantissa quotient built by a restoring divider, one bit per cycle. Fixed latency regardless of operand values.

---
 rtl/float_pkg.sv | 36 +++
 rtl/div_float_if.sv | 29 ++
 rtl/frac_div_restoring.sv | 61 ++++++
 rtl/div_float.sv | 219 +++++++++++++++++++++
 tb/tb_div_float.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared IEEE-754 helpers for the floating-point arithmetic blocks.
// Field widths, bias, exponent limit and special-value encodings are
// functions of the operand width (64 -> double, anything else -> single),
// so a parameterized block can derive all of them from FLOAT_WIDTH alone.
package float_pkg;

  typedef enum logic [1:0] {IDLE, ITER, ROUND} state_t;

  function automatic int exp_width(input int fw);
    return (fw == 64) ? 11 : 8;
  endfunction

  function automatic int frac_width(input int fw);
    return (fw == 64) ? 52 : 23;
  endfunction

  // Exponent bias.
  function automatic int exp_shift(input int fw);
    return (1 << (exp_width(fw) - 1)) - 1;
  endfunction

  // All-ones exponent: first value that no longer encodes a finite number.
  function automatic int exp_max(input int fw);
    return (1 << exp_width(fw)) - 1;
  endfunction

  // Returned 64 bits wide; single-precision users take the low 32 bits.
  function automatic logic [63:0] nan_value(input int fw);
    return (fw == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_FFC0_0000;
  endfunction

  function automatic logic [63:0] inf_value(input int fw);
    return (fw == 64) ? 64'h7FF0_0000_0000_0000 : 64'h0000_0000_7F80_0000;
  endfunction

endpackage

// File: rtl/div_float_if.sv
// Start/done/flag bundle of the floating-point divider.
//   start, op1, op2        : requester -> divider
//   out_reg, *_reg flags   : divider -> requester, valid when done_reg pulses
// master = requester side, slave = divider side.
interface div_float_if #(parameter int FLOAT_WIDTH = 64);
  logic                   start;
  logic [FLOAT_WIDTH-1:0] op1;
  logic [FLOAT_WIDTH-1:0] op2;
  logic [FLOAT_WIDTH-1:0] out_reg;
  logic                   nan_reg;
  logic                   overflow_reg;
  logic                   underflow_reg;
  logic                   zero_reg;
  logic                   div_by_zero_reg;
  logic                   busy_reg;
  logic                   done_reg;

  modport master (
    output start, op1, op2,
    input  out_reg, nan_reg, overflow_reg, underflow_reg, zero_reg,
           div_by_zero_reg, busy_reg, done_reg
  );

  modport slave (
    input  start, op1, op2,
    output out_reg, nan_reg, overflow_reg, underflow_reg, zero_reg,
           div_by_zero_reg, busy_reg, done_reg
  );
endinterface

// File: rtl/frac_div_restoring.sv
// Restoring mantissa divider, one quotient bit per step.
//   clk, rst : clock, synchronous active-high reset
//   load     : take {1,frac1} as remainder, {1,frac2} as divisor, clear Q
//   step     : produce the next quotient bit (MSB first)
//   quo      : F+3-bit quotient; bit F+2 weighs 2^0 of the mantissa ratio
// Both mantissas are in [1,2), so the ratio is in (0.5,2): the first bit
// or the second is always 1, leaving a guard bit below the fraction.
module frac_div_restoring #(
  parameter int F = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [F-1:0] frac1,
  input  logic [F-1:0] frac2,
  output logic [F+2:0] quo
);

  // remainder < 2*divisor always holds, so F+2 bits suffice
  logic [F+1:0] rem_q, rem_d;
  logic [F:0]   dvs_q, dvs_d;
  logic [F+2:0] q_q, q_d;
  logic [F+2:0] trial;

  always_comb begin
    trial = {1'b0, rem_q} - {2'b00, dvs_q};
    rem_d = rem_q;
    dvs_d = dvs_q;
    q_d   = q_q;
    if (load) begin
      rem_d = {2'b01, frac1};
      dvs_d = {1'b1, frac2};
      q_d   = '0;
    end else if (step) begin
      if (!trial[F+2]) begin
        // trial < divisor < 2^(F+1): the top bits are zero, shift is lossless
        rem_d = {trial[F:0], 1'b0};
        q_d   = {q_q[F+1:0], 1'b1};
      end else begin
        rem_d = {rem_q[F:0], 1'b0};
        q_d   = {q_q[F+1:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      q_q   <= '0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      q_q   <= q_d;
    end
  end

  assign quo = q_q;

endmodule

// File: rtl/div_float.sv
// Sequential IEEE-754 divider, op1 / op2, fixed latency F+4 cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_float_if slave (start/op1/op2 in; out_reg, flags,
//              busy_reg, done_reg out)
// start is accepted in any state and restarts the operation. The quotient
// mantissa comes from frac_div_restoring; this block runs the FSM, classifies
// the operands, computes exponent, rounds (half-up), packs and flags.
// Denormal operands are flushed to zero.
module div_float
  import float_pkg::*;
#(
  parameter int FLOAT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  div_float_if.slave  bus
);

  localparam int FW        = FLOAT_WIDTH;
  localparam int EW        = exp_width(FW);
  localparam int F         = frac_width(FW);
  localparam int EXP_SHIFT = exp_shift(FW);
  localparam int EXP_MAX   = exp_max(FW);
  localparam int NITER     = F + 3;
  localparam int CW        = $clog2(NITER);

  localparam logic [FW-1:0]        NAN_VALUE = FW'(nan_value(FW));
  localparam logic [FW-1:0]        INF_VALUE = FW'(inf_value(FW));
  localparam logic signed [EW+1:0] BIAS      = (EW+2)'(EXP_SHIFT);
  localparam logic signed [EW+1:0] E_MAX     = (EW+2)'(EXP_MAX);
  localparam logic signed [EW+1:0] E_ONE     = (EW+2)'(1);
  localparam logic signed [EW+1:0] E_ZERO    = '0;
  localparam logic [CW-1:0]        LAST      = CW'(NITER - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic            sign_q, sign_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [FW-1:0]   out_q, out_d;
  logic            nan_q, nan_d, ovf_q, ovf_d, unf_q, unf_d;
  logic            zero_q, zero_d, dbz_q, dbz_d;

  logic            load, step;
  logic [F+2:0]    quo;

  frac_div_restoring #(.F(F)) u_frac (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .frac1 (bus.op1[F-1:0]),
    .frac2 (bus.op2[F-1:0]),
    .quo   (quo)
  );

  // Result datapath, evaluated from the latched operands and final Q.
  logic [EW-1:0]          exp1, exp2;
  logic [F-1:0]           frac1, frac2, frac_raw, frac_rnd;
  logic [F:0]             frac_sum;
  logic                   guard;
  logic                   z1, z2, inf1, inf2, nan1, nan2, fin1, fin2;
  logic signed [EW+1:0]   e;
  logic [FW-1:0]          res_out;
  logic                   res_nan, res_ovf, res_unf, res_zero, res_dbz;

  always_comb begin
    exp1  = op1_q[FW-2:F];
    exp2  = op2_q[FW-2:F];
    frac1 = op1_q[F-1:0];
    frac2 = op2_q[F-1:0];
    z1    = (exp1 == '0);
    z2    = (exp2 == '0);
    fin1  = ~&exp1;
    fin2  = ~&exp2;
    inf1  = (&exp1) && (frac1 == '0);
    inf2  = (&exp2) && (frac2 == '0);
    nan1  = (&exp1) && (|frac1);
    nan2  = (&exp2) && (|frac2);

    e = $signed({2'b00, exp1}) - $signed({2'b00, exp2}) + BIAS;
    // ratio < 1 leaves the leading one one position lower
    if (quo[F+2]) begin
      frac_raw = quo[F+1:2];
      guard    = quo[1];
    end else begin
      frac_raw = quo[F:1];
      guard    = quo[0];
      e        = e - E_ONE;
    end
    frac_sum = {1'b0, frac_raw} + {{F{1'b0}}, guard};
    frac_rnd = frac_sum[F-1:0];
    if (frac_sum[F]) begin
      frac_rnd = '0;
      e        = e + E_ONE;
    end

    res_out  = '0;
    res_nan  = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    res_zero = 1'b0;
    res_dbz  = 1'b0;
    if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2)) begin
      res_out = NAN_VALUE;
      res_nan = 1'b1;
    end else if (fin1 && !z1 && z2) begin
      res_out = {sign_q, INF_VALUE[FW-2:0]};
      res_dbz = 1'b1;
    end else if (inf1) begin
      res_out = {sign_q, INF_VALUE[FW-2:0]};
    end else if (z1 || inf2) begin
      res_out  = {sign_q, {(FW-1){1'b0}}};
      res_zero = 1'b1;
    end else if (e >= E_MAX) begin
      res_out = {sign_q, INF_VALUE[FW-2:0]};
      res_ovf = 1'b1;
    end else if (e <= E_ZERO) begin
      res_out  = {sign_q, {(FW-1){1'b0}}};
      res_unf  = 1'b1;
      res_zero = 1'b1;
    end else begin
      res_out = {sign_q, e[EW-1:0], frac_rnd};
    end
  end

  // Next-state / control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    nan_d   = nan_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    load    = 1'b0;
    step    = 1'b0;

    if (bus.start) begin
      // restart wins over everything, including a pending ROUND
      load    = 1'b1;
      op1_d   = bus.op1;
      op2_d   = bus.op2;
      sign_d  = bus.op1[FW-1] ^ bus.op2[FW-1];
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = ITER;
    end else begin
      unique case (state_q)
        ITER: begin
          step = 1'b1;
          if (cnt_q == LAST) state_d = ROUND;
          else               cnt_d   = cnt_q + 1'b1;
        end
        ROUND: begin
          out_d   = res_out;
          nan_d   = res_nan;
          ovf_d   = res_ovf;
          unf_d   = res_unf;
          zero_d  = res_zero;
          dbz_d   = res_dbz;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      nan_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      nan_q   <= nan_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.out_reg         = out_q;
  assign bus.nan_reg         = nan_q;
  assign bus.overflow_reg    = ovf_q;
  assign bus.underflow_reg   = unf_q;
  assign bus.zero_reg        = zero_q;
  assign bus.div_by_zero_reg = dbz_q;
  assign bus.busy_reg        = busy_q;
  assign bus.done_reg        = done_q;

endmodule

// File: tb/tb_div_float.sv
// Directed bench for div_float (32-bit and 64-bit instances).
// Expected results go into a scoreboard queue at start; the front entry is
// popped and compared when done_reg pulses. Flags are compared as
// {nan, overflow, underflow, zero, div_by_zero}.
module tb_div_float;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_float_if #(.FLOAT_WIDTH(32)) b32 ();
  div_float_if #(.FLOAT_WIDTH(64)) b64 ();

  div_float #(.FLOAT_WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
  div_float #(.FLOAT_WIDTH(64)) u64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct {
    string       tag;
    bit          w64;
    logic [63:0] out;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] obs_out(input bit w64);
    return w64 ? b64.out_reg : {32'b0, b32.out_reg};
  endfunction

  function automatic logic [4:0] obs_flags(input bit w64);
    return w64 ? {b64.nan_reg, b64.overflow_reg, b64.underflow_reg, b64.zero_reg, b64.div_by_zero_reg}
               : {b32.nan_reg, b32.overflow_reg, b32.underflow_reg, b32.zero_reg, b32.div_by_zero_reg};
  endfunction

  function automatic logic obs_done(input bit w64);
    return w64 ? b64.done_reg : b32.done_reg;
  endfunction

  function automatic logic obs_busy(input bit w64);
    return w64 ? b64.busy_reg : b32.busy_reg;
  endfunction

  // One-cycle start pulse; returns at the negedge after the sampling edge.
  task automatic drive_start(input bit w64, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    if (w64) begin
      b64.op1 = a; b64.op2 = b; b64.start = 1'b1;
    end else begin
      b32.op1 = a[31:0]; b32.op2 = b[31:0]; b32.start = 1'b1;
    end
    @(negedge clk);
    b32.start = 1'b0;
    b64.start = 1'b0;
    // operand changes after the start edge must not matter
    b32.op1 = 32'h1234_5678; b32.op2 = 32'h4000_0000;
    b64.op1 = 64'h1234_5678_9ABC_DEF0; b64.op2 = 64'h4000_0000_0000_0000;
  endtask

  task automatic push(input string tag, input bit w64, input logic [63:0] o, input logic [4:0] f);
    exp_t x;
    x.tag = tag; x.w64 = w64; x.out = o; x.flags = f;
    sb.push_back(x);
  endtask

  // Call right after drive_start: counts cycles to done, pops and compares.
  task automatic wait_done();
    exp_t x;
    int   n;
    int   lat;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    x   = sb.pop_front();
    lat = x.w64 ? 56 : 27;
    n   = 0;
    chk({x.tag, "_busy"}, {63'b0, obs_busy(x.w64)}, 64'd1);
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (obs_done(x.w64)) break;
    end
    chk({x.tag, "_latency"}, n, lat);
    chk({x.tag, "_out"}, obs_out(x.w64), x.out);
    chk({x.tag, "_flags"}, {59'b0, obs_flags(x.w64)}, {59'b0, x.flags});
    chk({x.tag, "_busy_low"}, {63'b0, obs_busy(x.w64)}, 64'd0);
    @(negedge clk);
    chk({x.tag, "_pulse"}, {63'b0, obs_done(x.w64)}, 64'd0);
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] o, input logic [4:0] f);
    push(tag, 1'b0, {32'b0, o}, f);
    drive_start(1'b0, {32'b0, a}, {32'b0, b});
    wait_done();
  endtask

  initial begin
    int early;
    rst = 1'b1;
    b32.start = 1'b0; b32.op1 = '0; b32.op2 = '0;
    b64.start = 1'b0; b64.op1 = '0; b64.op2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_out32", obs_out(1'b0), 64'd0);
    chk("reset_flags32", {59'b0, obs_flags(1'b0)}, 64'd0);
    chk("reset_busydone32", {62'b0, obs_busy(1'b0), obs_done(1'b0)}, 64'd0);
    chk("reset_out64", obs_out(1'b1), 64'd0);
    rst = 1'b0;

    op32("div_6_2",     32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000);
    op32("div_1_3",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 5'b00000);
    op32("div_m1_3",    32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 5'b00000);
    op32("div_m6_2",    32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 5'b00000);
    op32("div_1_0",     32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b00001);
    op32("div_0_0",     32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 5'b10000);
    op32("div_inf_inf", 32'h7F80_0000, 32'h7F80_0000, 32'hFFC0_0000, 5'b10000);
    op32("div_nan_1",   32'h7FC0_0001, 32'h3F80_0000, 32'hFFC0_0000, 5'b10000);
    op32("div_inf_1",   32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 5'b00000);
    op32("div_1_inf",   32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 5'b00010);
    op32("div_0_m2",    32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 5'b00010);
    op32("overflow",    32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 5'b01000);
    op32("underflow",   32'h0080_0000, 32'h4080_0000, 32'h0000_0000, 5'b00110);

    // restart 10 cycles into 6/2 with 10/5; only the new one may finish
    drive_start(1'b0, 64'h40C0_0000, 64'h4000_0000);
    early = 0;
    repeat (9) begin
      @(negedge clk);
      if (b32.done_reg) early++;
    end
    push("restart_10_5", 1'b0, 64'h4000_0000, 5'b00000);
    drive_start(1'b0, 64'h4120_0000, 64'h40A0_0000);
    chk("restart_no_early_done", early, 0);
    wait_done();

    // second start lands on the ROUND edge of the first: no done for the first
    drive_start(1'b0, 64'h40C0_0000, 64'h4000_0000);
    repeat (25) @(negedge clk);
    push("collide_1_3", 1'b0, 64'h3EAA_AAAB, 5'b00000);
    drive_start(1'b0, 64'h3F80_0000, 64'h4040_0000);
    chk("collide_no_old_done", {63'b0, b32.done_reg}, 64'd0);
    wait_done();

    // reset 5 cycles into an operation
    drive_start(1'b0, 64'h40C0_0000, 64'h4000_0000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_out", obs_out(1'b0), 64'd0);
    chk("rst_mid_flags", {59'b0, obs_flags(1'b0)}, 64'd0);
    chk("rst_mid_busydone", {62'b0, obs_busy(1'b0), obs_done(1'b0)}, 64'd0);
    early = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.done_reg) early++;
    end
    chk("rst_mid_no_done", early, 0);

    // double precision
    push("dp_6_2", 1'b1, 64'h4008_0000_0000_0000, 5'b00000);
    drive_start(1'b1, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000);
    wait_done();
    push("dp_1_0", 1'b1, 64'h7FF0_0000_0000_0000, 5'b00001);
    drive_start(1'b1, 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0000);
    wait_done();

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
